// File: rtl/tlul_master_port.sv
// Single-outstanding TL-UL initiator: one local command becomes one A beat (Get/PutFullData/PutPartialData),
// and the matching D beat becomes one local response. Optional D-wait timeout: define TLUL_MASTER_TIMEOUT_EN.
module tlul_master_port #(
  parameter int SIZEBITS    = 4,
  parameter int SOURCEBITS  = 3,
  parameter int ADDRESSBITS = 12,
  parameter int MASKBITS    = 4,
  parameter int DATABITS    = 32,
  parameter int SINKBITS    = 1,
  parameter int SOURCEID    = 0,
  parameter int TIMEOUT     = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_cmd_valid,
  output logic                          io_cmd_ready,
  input  logic                          io_cmd_bits_write,
  input  logic [ADDRESSBITS-1:0]        io_cmd_bits_address,
  input  logic [DATABITS-1:0]           io_cmd_bits_data,
  input  logic [MASKBITS-1:0]           io_cmd_bits_mask,
  output logic                          io_rsp_valid,
  input  logic                          io_rsp_ready,
  output logic [DATABITS-1:0]           io_rsp_bits_data,
  output logic                          io_rsp_bits_error,
  output logic                          io_rsp_bits_write,
  input  logic                          io_master_a_ready,
  output logic                          io_master_a_valid,
  output logic [2:0]                    io_master_a_bits_opcode,
  output logic [2:0]                    io_master_a_bits_param,
  output logic [SIZEBITS-1:0]           io_master_a_bits_size,
  output logic [SOURCEBITS-1:0]         io_master_a_bits_source,
  output logic [ADDRESSBITS-1:0]        io_master_a_bits_address,
  output logic [MASKBITS-1:0]           io_master_a_bits_mask,
  output logic [DATABITS-1:0]           io_master_a_bits_data,
  output logic                          io_master_d_ready,
  input  logic                          io_master_d_valid,
  input  logic [2:0]                    io_master_d_bits_opcode,
  input  logic [1:0]                    io_master_d_bits_param,
  input  logic [SIZEBITS-1:0]           io_master_d_bits_size,
  input  logic [SOURCEBITS-1:0]         io_master_d_bits_source,
  input  logic [SINKBITS-1:0]           io_master_d_bits_sink,
  input  logic [$clog2(MASKBITS)-1:0]   io_master_d_bits_addr_lo,
  input  logic [DATABITS-1:0]           io_master_d_bits_data,
  input  logic                          io_master_d_bits_error
);

  localparam int         LGMASK      = $clog2(MASKBITS);
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_D = 2'd2,
    RSP    = 2'd3
  } state_t;

  state_t                   state_r, state_s;
  logic                     cmd_ready_r, cmd_ready_s;
  logic                     a_valid_r, a_valid_s;
  logic                     d_ready_r, d_ready_s;
  logic                     rsp_valid_r, rsp_valid_s;
  logic                     write_r, write_s;
  logic [2:0]               opcode_r, opcode_s;
  logic [ADDRESSBITS-1:0]   addr_r, addr_s;
  logic [MASKBITS-1:0]      mask_r, mask_s;
  logic [DATABITS-1:0]      data_r, data_s;
  logic [DATABITS-1:0]      rsp_data_r, rsp_data_s;
  logic                     rsp_error_r, rsp_error_s;
  logic                     cmd_fire_s, a_fire_s, d_fire_s, rsp_fire_s;
  logic                     unused_s;

`ifdef TLUL_MASTER_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT) + 1;
  logic [CNTW-1:0]          cnt_r, cnt_s;
  logic                     stale_r, stale_s;
`endif

  function automatic logic misaligned(input logic [ADDRESSBITS-1:0] addr);
    misaligned = (addr & ADDRESSBITS'(MASKBITS - 1)) != {ADDRESSBITS{1'b0}};
  endfunction

  // A read must be answered with AccessAckData, a write with AccessAck, from our own source.
  function automatic logic bad_resp(input logic wr, input logic [2:0] op,
                                    input logic [SOURCEBITS-1:0] src, input logic err);
    logic [2:0] exp_op;
    exp_op   = wr ? OP_ACK : OP_ACK_DATA;
    bad_resp = err || (src != SOURCEBITS'(SOURCEID)) || (op != exp_op);
  endfunction

  assign cmd_fire_s = io_cmd_valid && cmd_ready_r;
  assign a_fire_s   = a_valid_r && io_master_a_ready;
  assign d_fire_s   = io_master_d_valid && d_ready_r;
  assign rsp_fire_s = rsp_valid_r && io_rsp_ready;

  // Next-state, holding-register and handshake computation.
  always_comb begin
    state_s     = state_r;
    write_s     = write_r;
    opcode_s    = opcode_r;
    addr_s      = addr_r;
    mask_s      = mask_r;
    data_s      = data_r;
    rsp_data_s  = rsp_data_r;
    rsp_error_s = rsp_error_r;
`ifdef TLUL_MASTER_TIMEOUT_EN
    cnt_s       = cnt_r;
    stale_s     = (stale_r && d_fire_s && (state_r != WAIT_D)) ? 1'b0 : stale_r;
`endif
    case (state_r)
      IDLE: begin
        if (cmd_fire_s) begin
          write_s = io_cmd_bits_write;
          addr_s  = io_cmd_bits_address;
          if (io_cmd_bits_write) begin
            opcode_s = (io_cmd_bits_mask == {MASKBITS{1'b1}}) ? OP_PUT_FULL : OP_PUT_PART;
            mask_s   = io_cmd_bits_mask;
            data_s   = io_cmd_bits_data;
          end else begin
            opcode_s = OP_GET;
            mask_s   = {MASKBITS{1'b1}};
            data_s   = {DATABITS{1'b0}};
          end
          if (misaligned(io_cmd_bits_address)) begin
            state_s     = RSP;
            rsp_error_s = 1'b1;
            rsp_data_s  = {DATABITS{1'b0}};
          end else begin
            state_s = REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (a_fire_s) begin
          state_s = WAIT_D;
`ifdef TLUL_MASTER_TIMEOUT_EN
          cnt_s   = {CNTW{1'b0}};
`endif
        end else begin
          state_s = REQ;
        end
      end
      WAIT_D: begin
        if (d_fire_s) begin
          state_s     = RSP;
          rsp_error_s = bad_resp(write_r, io_master_d_bits_opcode,
                                 io_master_d_bits_source, io_master_d_bits_error);
          rsp_data_s  = (!write_r && !rsp_error_s) ? io_master_d_bits_data : {DATABITS{1'b0}};
        end
`ifdef TLUL_MASTER_TIMEOUT_EN
        else if (cnt_r == CNTW'(TIMEOUT - 1)) begin
          state_s     = RSP;
          rsp_error_s = 1'b1;
          rsp_data_s  = {DATABITS{1'b0}};
          stale_s     = 1'b1;
        end else begin
          cnt_s = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
        end
`else
        else begin
          state_s = WAIT_D;
        end
`endif
      end
      RSP: begin
        if (rsp_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = RSP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // Handshakes are registered from the next state so they are glitch-free flop outputs.
    a_valid_s   = (state_s == REQ);
    rsp_valid_s = (state_s == RSP);
`ifdef TLUL_MASTER_TIMEOUT_EN
    cmd_ready_s = (state_s == IDLE) && !stale_s;
    d_ready_s   = (state_s == WAIT_D) || stale_s;
`else
    cmd_ready_s = (state_s == IDLE);
    d_ready_s   = (state_s == WAIT_D);
`endif
  end

  // State, handshake and holding registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      a_valid_r   <= 1'b0;
      d_ready_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      write_r     <= 1'b0;
      opcode_r    <= 3'd0;
      addr_r      <= {ADDRESSBITS{1'b0}};
      mask_r      <= {MASKBITS{1'b0}};
      data_r      <= {DATABITS{1'b0}};
      rsp_data_r  <= {DATABITS{1'b0}};
      rsp_error_r <= 1'b0;
`ifdef TLUL_MASTER_TIMEOUT_EN
      cnt_r       <= {CNTW{1'b0}};
      stale_r     <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= cmd_ready_s;
      a_valid_r   <= a_valid_s;
      d_ready_r   <= d_ready_s;
      rsp_valid_r <= rsp_valid_s;
      write_r     <= write_s;
      opcode_r    <= opcode_s;
      addr_r      <= addr_s;
      mask_r      <= mask_s;
      data_r      <= data_s;
      rsp_data_r  <= rsp_data_s;
      rsp_error_r <= rsp_error_s;
`ifdef TLUL_MASTER_TIMEOUT_EN
      cnt_r       <= cnt_s;
      stale_r     <= stale_s;
`endif
    end
  end

  assign io_cmd_ready             = cmd_ready_r;
  assign io_master_a_valid        = a_valid_r;
  assign io_master_a_bits_opcode  = opcode_r;
  assign io_master_a_bits_param   = 3'b000;
  assign io_master_a_bits_size    = SIZEBITS'(LGMASK);
  assign io_master_a_bits_source  = SOURCEBITS'(SOURCEID);
  assign io_master_a_bits_address = addr_r;
  assign io_master_a_bits_mask    = mask_r;
  assign io_master_a_bits_data    = data_r;
  assign io_master_d_ready        = d_ready_r;
  assign io_rsp_valid             = rsp_valid_r;
  assign io_rsp_bits_data         = rsp_data_r;
  assign io_rsp_bits_error        = rsp_error_r;
  assign io_rsp_bits_write        = write_r;

`ifdef TLUL_MASTER_TIMEOUT_EN
  assign unused_s = ^{io_master_d_bits_param, io_master_d_bits_size,
                      io_master_d_bits_sink, io_master_d_bits_addr_lo};
`else
  assign unused_s = ^{io_master_d_bits_param, io_master_d_bits_size,
                      io_master_d_bits_sink, io_master_d_bits_addr_lo, (TIMEOUT > 0)};
`endif

endmodule

// File: tb/tb_tlul_master_port.sv
// Directed scoreboard bench for tlul_master_port: expected responses are queued when a command is
// driven and compared when the local response handshake completes.
module tb_tlul_master_port;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MW   = 4;
  localparam int SZW  = 4;
  localparam int SRCW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            io_cmd_valid, io_cmd_ready, io_cmd_bits_write;
  logic [AW-1:0]   io_cmd_bits_address;
  logic [DW-1:0]   io_cmd_bits_data;
  logic [MW-1:0]   io_cmd_bits_mask;
  logic            io_rsp_valid, io_rsp_ready, io_rsp_bits_error, io_rsp_bits_write;
  logic [DW-1:0]   io_rsp_bits_data;
  logic            io_master_a_ready, io_master_a_valid;
  logic [2:0]      io_master_a_bits_opcode, io_master_a_bits_param;
  logic [SZW-1:0]  io_master_a_bits_size;
  logic [SRCW-1:0] io_master_a_bits_source;
  logic [AW-1:0]   io_master_a_bits_address;
  logic [MW-1:0]   io_master_a_bits_mask;
  logic [DW-1:0]   io_master_a_bits_data;
  logic            io_master_d_ready, io_master_d_valid, io_master_d_bits_error;
  logic [2:0]      io_master_d_bits_opcode;
  logic [1:0]      io_master_d_bits_param;
  logic [SZW-1:0]  io_master_d_bits_size;
  logic [SRCW-1:0] io_master_d_bits_source;
  logic [0:0]      io_master_d_bits_sink;
  logic [1:0]      io_master_d_bits_addr_lo;
  logic [DW-1:0]   io_master_d_bits_data;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          error;
    logic          write;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   a_beats  = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (io_master_a_valid && io_master_a_ready) a_beats <= a_beats + 1;
  end

  tlul_master_port #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_bits_write(io_cmd_bits_write), .io_cmd_bits_address(io_cmd_bits_address),
    .io_cmd_bits_data(io_cmd_bits_data), .io_cmd_bits_mask(io_cmd_bits_mask),
    .io_rsp_valid(io_rsp_valid), .io_rsp_ready(io_rsp_ready),
    .io_rsp_bits_data(io_rsp_bits_data), .io_rsp_bits_error(io_rsp_bits_error),
    .io_rsp_bits_write(io_rsp_bits_write),
    .io_master_a_ready(io_master_a_ready), .io_master_a_valid(io_master_a_valid),
    .io_master_a_bits_opcode(io_master_a_bits_opcode), .io_master_a_bits_param(io_master_a_bits_param),
    .io_master_a_bits_size(io_master_a_bits_size), .io_master_a_bits_source(io_master_a_bits_source),
    .io_master_a_bits_address(io_master_a_bits_address), .io_master_a_bits_mask(io_master_a_bits_mask),
    .io_master_a_bits_data(io_master_a_bits_data),
    .io_master_d_ready(io_master_d_ready), .io_master_d_valid(io_master_d_valid),
    .io_master_d_bits_opcode(io_master_d_bits_opcode), .io_master_d_bits_param(io_master_d_bits_param),
    .io_master_d_bits_size(io_master_d_bits_size), .io_master_d_bits_source(io_master_d_bits_source),
    .io_master_d_bits_sink(io_master_d_bits_sink), .io_master_d_bits_addr_lo(io_master_d_bits_addr_lo),
    .io_master_d_bits_data(io_master_d_bits_data), .io_master_d_bits_error(io_master_d_bits_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [60:0] a_vec();
    return {io_master_a_bits_opcode, io_master_a_bits_param, io_master_a_bits_size,
            io_master_a_bits_source, io_master_a_bits_address, io_master_a_bits_mask,
            io_master_a_bits_data};
  endfunction

  function automatic logic [33:0] rsp_vec();
    return {io_rsp_bits_data, io_rsp_bits_error, io_rsp_bits_write};
  endfunction

  // One complete command: drive it, act as the slave, then consume and score the response.
  task automatic xact(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [MW-1:0] wmask, input logic [2:0] exp_op,
                      input int a_hold, input int d_lat,
                      input logic [2:0] d_op, input logic [SRCW-1:0] d_src, input logic d_err,
                      input logic [DW-1:0] d_data, input int r_hold,
                      input logic exp_err, input logic [DW-1:0] exp_data);
    logic [60:0] exp_a;
    logic [1:0]  lo;
    int          beats0;
    int          n;
    rsp_t        want;
    lo = addr[1:0];
    exp_q.push_back('{data: exp_data, error: exp_err, write: wr});
    exp_a  = {exp_op, 3'd0, 4'd2, 3'd0, addr, (wr ? wmask : 4'hF), (wr ? wdata : 32'h0)};
    beats0 = a_beats;
    io_cmd_valid        = 1'b1;
    io_cmd_bits_write   = wr;
    io_cmd_bits_address = addr;
    io_cmd_bits_data    = wdata;
    io_cmd_bits_mask    = wmask;
    n = 0;
    while (!io_cmd_ready && n < 50) begin step(); n++; end
    if (n == 50) check("cmd_ready_wait", {63'd0, io_cmd_ready}, 64'd1);
    step();
    io_cmd_valid = 1'b0;
    if (lo != 2'b00) begin
      check("misaligned_no_a", {io_master_a_valid, io_master_d_ready}, 64'd0);
    end else begin
      check("a_valid_latency", {io_master_a_valid, io_master_d_ready, io_rsp_valid}, 64'h4);
      for (int i = 0; i < a_hold; i++) begin
        check("a_hold_stable", a_vec(), exp_a);
        step();
      end
      check("a_fields", a_vec(), exp_a);
      io_master_a_ready = 1'b1;
      step();
      io_master_a_ready = 1'b0;
      check("d_ready_wait_d", {io_master_a_valid, io_master_d_ready}, 64'h1);
      repeat (d_lat) step();
      io_master_d_valid       = 1'b1;
      io_master_d_bits_opcode = d_op;
      io_master_d_bits_source = d_src;
      io_master_d_bits_error  = d_err;
      io_master_d_bits_data   = d_data;
      n = 0;
      while (!io_master_d_ready && n < 50) begin step(); n++; end
      if (n == 50) check("d_ready_wait", {63'd0, io_master_d_ready}, 64'd1);
      step();
      io_master_d_valid = 1'b0;
    end
    check("rsp_valid_latency", {io_rsp_valid, io_master_a_valid, io_master_d_ready}, 64'h4);
    for (int i = 0; i < r_hold; i++) begin
      check("rsp_hold_stable", {rsp_vec(), io_cmd_ready}, {exp_q[0], 1'b0});
      step();
    end
    want = exp_q.pop_front();
    check("rsp_fields", rsp_vec(), want);
    io_rsp_ready = 1'b1;
    step();
    io_rsp_ready = 1'b0;
    check("cmd_ready_after_rsp", {io_cmd_ready, io_rsp_valid}, 64'h2);
    check("a_beat_count", a_beats - beats0, (lo != 2'b00) ? 64'd0 : 64'd1);
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog expired");
  end

  initial begin
    int n;
    io_cmd_valid = 1'b0; io_cmd_bits_write = 1'b0; io_cmd_bits_address = 12'h000;
    io_cmd_bits_data = 32'h0; io_cmd_bits_mask = 4'h0; io_rsp_ready = 1'b0;
    io_master_a_ready = 1'b0; io_master_d_valid = 1'b0; io_master_d_bits_opcode = 3'd0;
    io_master_d_bits_param = 2'd0; io_master_d_bits_size = 4'd2; io_master_d_bits_source = 3'd0;
    io_master_d_bits_sink = 1'b0; io_master_d_bits_addr_lo = 2'd0; io_master_d_bits_data = 32'h0;
    io_master_d_bits_error = 1'b0;

    #2;
    check("reset_handshake_rsp", {io_cmd_ready, io_master_a_valid, io_master_d_ready, io_rsp_valid,
                                  io_rsp_bits_data, io_rsp_bits_error, io_rsp_bits_write}, 64'd0);
    check("reset_a_fields", {io_master_a_bits_opcode, io_master_a_bits_address,
                             io_master_a_bits_mask, io_master_a_bits_data}, 64'd0);
    check("reset_const_fields", {io_master_a_bits_param, io_master_a_bits_size,
                                 io_master_a_bits_source}, {3'd0, 4'd2, 3'd0});
    #10 reset = 1'b1;
    step();
    check("idle_cmd_ready", {io_cmd_ready, io_master_a_valid, io_master_d_ready, io_rsp_valid}, 64'h8);

    // wr addr wdata mask exp_op a_hold d_lat d_op d_src d_err d_data r_hold exp_err exp_data
    xact(1'b0, 12'h004, 32'h0, 4'h0, 3'd4, 0, 3, 3'd1, 3'd0, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF);
    xact(1'b1, 12'h008, 32'h12345678, 4'hF, 3'd0, 0, 0, 3'd0, 3'd0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    xact(1'b1, 12'h008, 32'h12345678, 4'h3, 3'd1, 0, 1, 3'd0, 3'd0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    xact(1'b1, 12'h00C, 32'hA5A5A5A5, 4'h0, 3'd1, 0, 0, 3'd0, 3'd0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    xact(1'b0, 12'h010, 32'h0, 4'h0, 3'd4, 5, 2, 3'd1, 3'd0, 1'b0, 32'h0BADF00D, 4, 1'b0, 32'h0BADF00D);
    xact(1'b1, 12'h014, 32'hFEEDC0DE, 4'hC, 3'd1, 5, 0, 3'd0, 3'd0, 1'b0, 32'h0, 4, 1'b0, 32'h0);
    xact(1'b0, 12'h018, 32'h0, 4'h0, 3'd4, 0, 0, 3'd1, 3'd3, 1'b0, 32'hCAFEF00D, 0, 1'b1, 32'h0);
    xact(1'b0, 12'h01C, 32'h0, 4'h0, 3'd4, 0, 0, 3'd0, 3'd0, 1'b0, 32'h11111111, 0, 1'b1, 32'h0);
    xact(1'b0, 12'h020, 32'h0, 4'h0, 3'd4, 0, 1, 3'd1, 3'd0, 1'b1, 32'h55AA55AA, 0, 1'b1, 32'h0);
    xact(1'b1, 12'h024, 32'h0F0F0F0F, 4'hF, 3'd0, 0, 0, 3'd1, 3'd0, 1'b0, 32'h22222222, 0, 1'b1, 32'h0);
    xact(1'b0, 12'h006, 32'h0, 4'h0, 3'd4, 0, 0, 3'd1, 3'd0, 1'b0, 32'h0, 0, 1'b1, 32'h0);
    xact(1'b1, 12'h00A, 32'h77777777, 4'hF, 3'd0, 0, 0, 3'd0, 3'd0, 1'b0, 32'h0, 2, 1'b1, 32'h0);

    // A D beat offered while idle must be ignored.
    io_master_d_valid = 1'b1; io_master_d_bits_opcode = 3'd1; io_master_d_bits_source = 3'd0;
    io_master_d_bits_error = 1'b0;
    step(); step(); step();
    check("idle_d_ignored", {io_master_d_ready, io_rsp_valid, io_cmd_ready}, 64'h1);
    io_master_d_valid = 1'b0;

    // Reset asserted while waiting on the D channel.
    io_cmd_valid = 1'b1; io_cmd_bits_write = 1'b0; io_cmd_bits_address = 12'h030;
    step();
    io_cmd_valid = 1'b0;
    io_master_a_ready = 1'b1;
    step();
    io_master_a_ready = 1'b0;
    check("pre_reset_wait_d", {io_master_d_ready, io_master_a_valid}, 64'h2);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_handshake", {io_cmd_ready, io_master_a_valid, io_master_d_ready, io_rsp_valid,
                                  io_rsp_bits_data, io_rsp_bits_error, io_rsp_bits_write}, 64'd0);
    check("mid_reset_a_fields", {io_master_a_bits_opcode, io_master_a_bits_address,
                                 io_master_a_bits_mask, io_master_a_bits_data}, 64'd0);
    #2 reset = 1'b1;
    step();
    check("post_reset_idle", {io_cmd_ready, io_master_a_valid, io_master_d_ready, io_rsp_valid}, 64'h8);

`ifdef TLUL_MASTER_TIMEOUT_EN
    io_cmd_valid = 1'b1; io_cmd_bits_write = 1'b0; io_cmd_bits_address = 12'h040;
    step();
    io_cmd_valid = 1'b0;
    io_master_a_ready = 1'b1;
    step();
    io_master_a_ready = 1'b0;
    n = 0;
    while (!io_rsp_valid && n < 50) begin step(); n++; end
    check("timeout_wait_cycles", n, 64'd8);
    check("timeout_rsp", rsp_vec(), {32'h0, 1'b1, 1'b0});
    io_rsp_ready = 1'b1;
    step();
    io_rsp_ready = 1'b0;
    check("stale_blocks_cmd", {io_cmd_ready, io_master_d_ready}, 64'h1);
    step();
    check("stale_still_blocks", {io_cmd_ready, io_master_d_ready}, 64'h1);
    io_master_d_valid = 1'b1; io_master_d_bits_opcode = 3'd1; io_master_d_bits_data = 32'h99999999;
    step();
    io_master_d_valid = 1'b0;
    check("stale_drained", {io_cmd_ready, io_master_d_ready, io_rsp_valid}, 64'h4);
`else
    n = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
